// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds words from several requesters into a single uart_tx,
// keeping at most one word in flight and flagging transmitters that never accept a send.
module uart_tx_arbiter #(
  parameter int p_NUM_REQ     = 4,
  parameter int p_WORD_LEN    = 8,
  parameter int p_ACC_TIMEOUT = 16
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic [p_NUM_REQ-1:0]              i_req,
  input  logic [p_NUM_REQ*p_WORD_LEN-1:0]   i_req_data,
  output logic [p_NUM_REQ-1:0]              o_ack,
  output logic                              o_send_en,
  output logic [p_WORD_LEN-1:0]             o_send_data,
  input  logic                              i_send_rdy,
  output logic [2:0]                        o_grant_id,
  output logic                              o_busy,
  output logic                              o_err
);

  localparam int                   CNT_W     = $clog2(p_ACC_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(p_ACC_TIMEOUT - 1);
  localparam logic [p_NUM_REQ-1:0] ACK_ONE   = p_NUM_REQ'(1);
  localparam logic [2:0]           LAST_INIT = 3'(p_NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_ACC,
    S_WAIT_DONE
  } state_t;

  state_t                  state_reg, state_next;
  logic [p_WORD_LEN-1:0]   send_data_reg, send_data_next;
  logic [2:0]              grant_id_reg, grant_id_next;
  logic [2:0]              last_grant_reg, last_grant_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic [p_NUM_REQ-1:0]    ack_reg, ack_next;
  logic                    send_en_reg, send_en_next;
  logic                    err_reg, err_next;

  logic [p_WORD_LEN-1:0]   word [p_NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < p_NUM_REQ; gi++) begin : g_word
      assign word[gi] = i_req_data[gi*p_WORD_LEN +: p_WORD_LEN];
    end
  endgenerate

  // Round robin: lowest requester above last_grant wins, otherwise wrap to the lowest overall.
  logic                    any_req, found_hi;
  logic [2:0]              win_lo, win_hi, winner;
  logic [p_WORD_LEN-1:0]   data_lo, data_hi, win_data;

  always_comb begin
    any_req  = 1'b0;
    found_hi = 1'b0;
    win_lo   = '0;
    win_hi   = '0;
    data_lo  = '0;
    data_hi  = '0;
    for (int k = p_NUM_REQ - 1; k >= 0; k--) begin
      if (i_req[k]) begin
        any_req = 1'b1;
        win_lo  = 3'(k);
        data_lo = word[k];
        if (k > int'(last_grant_reg)) begin
          found_hi = 1'b1;
          win_hi   = 3'(k);
          data_hi  = word[k];
        end
      end
    end
    winner   = found_hi ? win_hi : win_lo;
    win_data = found_hi ? data_hi : data_lo;
  end

  always_comb begin
    state_next      = state_reg;
    send_data_next  = send_data_reg;
    grant_id_next   = grant_id_reg;
    last_grant_next = last_grant_reg;
    cnt_next        = cnt_reg;
    ack_next        = '0;
    send_en_next    = 1'b0;
    err_next        = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (i_send_rdy && any_req) begin
          send_data_next = win_data;
          grant_id_next  = winner;
          ack_next       = ACK_ONE << winner;
          state_next     = S_SEND;
        end
      end
      S_SEND: begin
        send_en_next = 1'b1;
        cnt_next     = '0;
        state_next   = S_WAIT_ACC;
      end
      S_WAIT_ACC: begin
        if (!i_send_rdy) begin
          state_next = S_WAIT_DONE;
        end else if (cnt_reg >= CNT_LAST) begin
          // A dropped word still consumes its turn so rotation moves on to the next requester.
          err_next        = 1'b1;
          last_grant_next = grant_id_reg;
          state_next      = S_IDLE;
        end else if (cnt_reg != '1) begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (i_send_rdy) begin
          last_grant_next = grant_id_reg;
          state_next      = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg      <= S_IDLE;
      send_data_reg  <= '0;
      grant_id_reg   <= '0;
      last_grant_reg <= LAST_INIT;
      cnt_reg        <= '0;
      ack_reg        <= '0;
      send_en_reg    <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      send_data_reg  <= send_data_next;
      grant_id_reg   <= grant_id_next;
      last_grant_reg <= last_grant_next;
      cnt_reg        <= cnt_next;
      ack_reg        <= ack_next;
      send_en_reg    <= send_en_next;
      err_reg        <= err_next;
    end
  end

  assign o_ack       = ack_reg;
  assign o_send_en   = send_en_reg;
  assign o_send_data = send_data_reg;
  assign o_grant_id  = grant_id_reg;
  assign o_err       = err_reg;
  assign o_busy      = (state_reg != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: 4 requesters, 8-bit words, 16-cycle acceptance timeout,
// with a small busy-counter stand-in for uart_tx during the rotation scenario.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic        rdy_man;
  logic        model_on = 1'b0;
  int          busy_cnt = 0;
  int          overlap  = 0;
  logic        send_rdy;
  logic [3:0]  ack;
  logic        send_en;
  logic [7:0]  send_data;
  logic [2:0]  grant_id;
  logic        busy;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign send_rdy = model_on ? (busy_cnt == 0) : rdy_man;

  uart_tx_arbiter #(
    .p_NUM_REQ(4),
    .p_WORD_LEN(8),
    .p_ACC_TIMEOUT(16)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_req(req),
    .i_req_data(req_data),
    .o_ack(ack),
    .o_send_en(send_en),
    .o_send_data(send_data),
    .i_send_rdy(send_rdy),
    .o_grant_id(grant_id),
    .o_busy(busy),
    .o_err(err)
  );

  // Transmitter stand-in: busy for 10 cycles after each accepted send pulse.
  always @(posedge clk) begin
    if (model_on) begin
      if (send_en) begin
        if (busy_cnt != 0) overlap <= overlap + 1;
        busy_cnt <= 10;
      end else if (busy_cnt != 0) begin
        busy_cnt <= busy_cnt - 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walks a granted word through SEND, acceptance and completion, ending in IDLE.
  task automatic complete_xfer(input logic [3:0] req_after);
    req = req_after;
    tick();
    rdy_man = 1'b0;
    tick();
    rdy_man = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    req      = 4'b0000;
    req_data = 32'h0;
    rdy_man  = 1'b1;
    tick();
    tick();
    n_checks++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack: got %b expected 0000", ack); end
    n_checks++; if (send_en !== 1'b0) begin n_fail++; $display("FAIL reset_send_en: got %b expected 0", send_en); end
    n_checks++; if (send_data !== 8'h00) begin n_fail++; $display("FAIL reset_send_data: got %h expected 00", send_data); end
    n_checks++; if (grant_id !== 3'd0) begin n_fail++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    req      = 4'b0001;
    req_data = 32'h0000_0048;
    tick();
    $display("basic: grant id=%0d data=%h", grant_id, send_data);
    n_checks++; if (ack !== 4'b0001) begin n_fail++; $display("FAIL basic_ack: got %b expected 0001", ack); end
    n_checks++; if (send_data !== 8'h48) begin n_fail++; $display("FAIL basic_data: got %h expected 48", send_data); end
    n_checks++; if (grant_id !== 3'd0) begin n_fail++; $display("FAIL basic_grant: got %0d expected 0", grant_id); end
    n_checks++; if (send_en !== 1'b0) begin n_fail++; $display("FAIL basic_early_send_en: got %b expected 0", send_en); end
    req      = 4'b0000;
    req_data = 32'h0;
    tick();
    n_checks++; if (send_en !== 1'b1) begin n_fail++; $display("FAIL basic_send_en: got %b expected 1", send_en); end
    n_checks++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL basic_ack_one_cycle: got %b expected 0000", ack); end
    rdy_man = 1'b0;
    tick();
    n_checks++; if (send_en !== 1'b0) begin n_fail++; $display("FAIL basic_send_en_one_cycle: got %b expected 0", send_en); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_wait_done: got %b expected 1", busy); end
    rdy_man = 1'b1;
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle: got %b expected 0", busy); end
    n_checks++; if (send_data !== 8'h48) begin n_fail++; $display("FAIL basic_data_hold: got %h expected 48", send_data); end
  endtask

  task automatic test_timeout();
    int seen;
    req      = 4'b0110;
    req_data = 32'h0033_2211;
    tick();
    $display("timeout: grant id=%0d data=%h", grant_id, send_data);
    n_checks++; if (grant_id !== 3'd1) begin n_fail++; $display("FAIL timeout_first_grant: got %0d expected 1", grant_id); end
    tick();
    seen = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (err) begin
        seen = i;
        break;
      end
    end
    n_checks++; if (seen != 16) begin n_fail++; $display("FAIL timeout_err_delay: got %0d cycles expected 16", seen); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_idle: got busy=%b expected 0", busy); end
    tick();
    $display("timeout: next grant id=%0d data=%h", grant_id, send_data);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL timeout_err_pulse: got %b expected 0", err); end
    n_checks++; if (ack !== 4'b0100) begin n_fail++; $display("FAIL timeout_next_ack: got %b expected 0100", ack); end
    n_checks++; if (send_data !== 8'h33) begin n_fail++; $display("FAIL timeout_next_data: got %h expected 33", send_data); end
    complete_xfer(4'b0000);
  endtask

  task automatic test_rdy_low();
    rdy_man = 1'b0;
    req     = 4'b0010;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL rdy_low_no_ack: got %b expected 0000", ack); end
    end
    rdy_man = 1'b1;
    tick();
    $display("rdy_low: grant id=%0d data=%h", grant_id, send_data);
    n_checks++; if (ack !== 4'b0010) begin n_fail++; $display("FAIL rdy_low_ack: got %b expected 0010", ack); end
    n_checks++; if (grant_id !== 3'd1) begin n_fail++; $display("FAIL rdy_low_grant: got %0d expected 1", grant_id); end
    complete_xfer(4'b0000);
  endtask

  task automatic test_rotation();
    int ng;
    int exp_id;
    logic [7:0] exp_d;
    rst_n = 1'b0;
    req   = 4'b0000;
    tick();
    rst_n    = 1'b1;
    model_on = 1'b1;
    req_data = 32'hA3A2_A1A0;
    req      = 4'b1111;
    ng       = 0;
    exp_id   = 0;
    for (int c = 0; c < 600 && ng < 5; c++) begin
      tick();
      if (ack != 4'b0000) begin
        exp_d = 8'hA0 + 8'(exp_id);
        $display("rotation: grant id=%0d data=%h", grant_id, send_data);
        n_checks++; if (grant_id !== 3'(exp_id)) begin n_fail++; $display("FAIL rotation_grant: got %0d expected %0d", grant_id, exp_id); end
        n_checks++; if (send_data !== exp_d) begin n_fail++; $display("FAIL rotation_data: got %h expected %h", send_data, exp_d); end
        n_checks++; if (busy_cnt != 0) begin n_fail++; $display("FAIL rotation_in_flight: got busy_cnt=%0d expected 0", busy_cnt); end
        ng++;
        exp_id = (exp_id + 1) % 4;
        if (ng == 5) req = 4'b0000;
      end
    end
    n_checks++; if (ng != 5) begin n_fail++; $display("FAIL rotation_count: got %0d grants expected 5", ng); end
    for (int c = 0; c < 200 && !(busy == 1'b0 && busy_cnt == 0); c++) tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rotation_drain: got busy=%b expected 0", busy); end
    n_checks++; if (overlap != 0) begin n_fail++; $display("FAIL rotation_overlap: got %0d expected 0", overlap); end
    model_on = 1'b0;
    rdy_man  = 1'b1;
  endtask

  task automatic test_reset_mid();
    req      = 4'b0001;
    req_data = 32'h8877_6655;
    tick();
    req = 4'b0000;
    tick();
    rdy_man = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 1", busy); end
    rst_n   = 1'b0;
    rdy_man = 1'b1;
    tick();
    n_checks++; if ({ack, send_en, send_data, grant_id, busy, err} !== 18'h0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got ack=%b en=%b data=%h id=%0d busy=%b err=%b expected all 0", ack, send_en, send_data, grant_id, busy, err);
    end
    rst_n = 1'b1;
    req   = 4'b1000;
    tick();
    $display("reset_mid: grant id=%0d data=%h", grant_id, send_data);
    n_checks++; if (ack !== 4'b1000) begin n_fail++; $display("FAIL rstmid_ack: got %b expected 1000", ack); end
    n_checks++; if (grant_id !== 3'd3) begin n_fail++; $display("FAIL rstmid_grant: got %0d expected 3", grant_id); end
    complete_xfer(4'b0000);
  endtask

  task automatic test_drop();
    logic [3:0] acks_seen;
    req      = 4'b0111;
    req_data = 32'hD3D2_D1D0;
    tick();
    $display("drop: grant id=%0d data=%h", grant_id, send_data);
    n_checks++; if (ack !== 4'b0001) begin n_fail++; $display("FAIL drop_first_ack: got %b expected 0001", ack); end
    req = 4'b0110;
    tick();
    rdy_man = 1'b0;
    tick();
    req     = 4'b0010;
    rdy_man = 1'b1;
    tick();
    tick();
    acks_seen = ack;
    $display("drop: grant id=%0d data=%h", grant_id, send_data);
    n_checks++; if (ack !== 4'b0010) begin n_fail++; $display("FAIL drop_second_ack: got %b expected 0010", ack); end
    complete_xfer(4'b1000);
    tick();
    acks_seen = acks_seen | ack;
    $display("drop: grant id=%0d data=%h", grant_id, send_data);
    n_checks++; if (grant_id !== 3'd3) begin n_fail++; $display("FAIL drop_skip_grant: got %0d expected 3", grant_id); end
    n_checks++; if (acks_seen[2] !== 1'b0) begin n_fail++; $display("FAIL drop_never_acked: got %b expected 0", acks_seen[2]); end
    complete_xfer(4'b0000);
  endtask

  task automatic test_single();
    req      = 4'b0100;
    req_data = 32'h005A_0000;
    for (int r = 0; r < 3; r++) begin
      tick();
      $display("single: grant id=%0d data=%h", grant_id, send_data);
      n_checks++; if (ack !== 4'b0100) begin n_fail++; $display("FAIL single_ack: got %b expected 0100", ack); end
      n_checks++; if (send_data !== 8'h5A) begin n_fail++; $display("FAIL single_data: got %h expected 5a", send_data); end
      complete_xfer(4'b0100);
    end
    req = 4'b0000;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_rdy_low();
    test_rotation();
    test_reset_mid();
    test_drop();
    test_single();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
